// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit CPU: instruction-memory FSM states and
// the default memory geometry and NOP encoding.
package cpu_pkg;

  localparam int ADDR_W_DEFAULT = 4;
  localparam int DATA_W_DEFAULT = 8;

  // NOP encoding; also the value the instruction memory clears itself to.
  localparam logic [7:0] NOP_WORD = 8'b0010_0000;

  typedef enum logic [1:0] {
    CLEAR,
    RUN,
    LOAD
  } mem_state_t;

endpackage

// File: rtl/instr_mem_array.sv
// Single-port instruction RAM: synchronous write, registered read.
module instr_mem_array #(
  parameter int ADDR_W = cpu_pkg::ADDR_W_DEFAULT,
  parameter int DATA_W = cpu_pkg::DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // NOTE: the array has no reset so it maps onto RAM macros; the owning FSM
  // clears it word by word after reset instead.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/instr_mem.sv
// Writable instruction memory: self-clears after reset, accepts a streamed
// program load, and serves one-cycle registered fetches while in RUN.
module instr_mem
  import cpu_pkg::*;
#(
  parameter int                ADDR_W    = ADDR_W_DEFAULT,
  parameter int                DATA_W    = DATA_W_DEFAULT,
  parameter logic [DATA_W-1:0] FILL_WORD = DATA_W'(NOP_WORD)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_en,
  input  logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] instruction,
  output logic              instr_valid,
  output logic              busy,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  output logic              load_done
);

  mem_state_t        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q;
  logic              ptr_last;
  logic              load_end;

  logic              mem_we;
  logic              mem_re;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              instr_valid_q;
  logic [DATA_W-1:0] hold_q;
  logic              load_done_q;

  assign ptr_last = &ptr_q;
  // A load ends on a flagged word or on the top address; it never wraps.
  assign load_end = (state_q == LOAD) && load_valid && (load_last || ptr_last);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      CLEAR:   if (ptr_last)   state_d = RUN;
      RUN:     if (load_start) state_d = LOAD;
      LOAD:    if (load_end)   state_d = RUN;
      default:                 state_d = CLEAR;
    endcase
  end

  // NOTE: every output of this block gets a default first, so no path
  // through the case can infer a latch.
  always_comb begin
    busy       = 1'b1;
    load_ready = 1'b0;
    mem_we     = 1'b0;
    mem_re     = 1'b0;
    mem_addr   = ptr_q;
    mem_wdata  = FILL_WORD;
    unique case (state_q)
      CLEAR: begin
        mem_we = 1'b1;
      end
      RUN: begin
        busy     = 1'b0;
        mem_re   = fetch_en;
        mem_addr = address;
      end
      LOAD: begin
        load_ready = 1'b1;
        mem_we     = load_valid;
        mem_wdata  = load_data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      unique case (state_q)
        CLEAR:   ptr_q <= ptr_q + 1'b1;
        RUN:     if (load_start) ptr_q <= '0;
        LOAD:    if (load_valid) ptr_q <= ptr_q + 1'b1;
        default: ptr_q <= '0;
      endcase
    end
  end

  instr_mem_array #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_array (
    .clk  (clk),
    .we   (mem_we),
    .re   (mem_re),
    .addr (mem_addr),
    .wdata(mem_wdata),
    .rdata(mem_rdata)
  );

  // The RAM output only updates on a fetch; hold_q keeps the last served
  // word so instruction stays stable and has a defined reset value.
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_valid_q <= 1'b0;
      hold_q        <= FILL_WORD;
      load_done_q   <= 1'b0;
    end else begin
      instr_valid_q <= mem_re;
      load_done_q   <= load_end;
      if (instr_valid_q) begin
        hold_q <= mem_rdata;
      end
    end
  end

  assign instruction = instr_valid_q ? mem_rdata : hold_q;
  assign instr_valid = instr_valid_q;
  assign load_done   = load_done_q;

endmodule

// File: tb/tb_instr_mem.sv
// Self-checking bench for instr_mem: fetch expectations go through a
// scoreboard queue and are matched against instr_valid by a monitor.
module tb_instr_mem;

  localparam int AW = 4;
  localparam int DW = 8;
  localparam int DEPTH = 16;
  localparam logic [DW-1:0] FILL = 8'h20;

  logic          clk = 1'b0;
  logic          rst;
  logic          fetch_en;
  logic [AW-1:0] address;
  logic [DW-1:0] instruction;
  logic          instr_valid;
  logic          busy;
  logic          load_start;
  logic          load_valid;
  logic [DW-1:0] load_data;
  logic          load_last;
  logic          load_ready;
  logic          load_done;

  instr_mem #(.ADDR_W(AW), .DATA_W(DW), .FILL_WORD(FILL)) dut (
    .clk        (clk),
    .rst        (rst),
    .fetch_en   (fetch_en),
    .address    (address),
    .instruction(instruction),
    .instr_valid(instr_valid),
    .busy       (busy),
    .load_start (load_start),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_last  (load_last),
    .load_ready (load_ready),
    .load_done  (load_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [7:0]  data;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] model [DEPTH];
  int         cyc = 0;
  int         done_cnt = 0;
  int         n_cmp = 0;
  int         n_err = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (load_done === 1'b1) done_cnt <= done_cnt + 1;
  end

  // Match each served fetch against the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b0) begin
      if (instr_valid === 1'b1) begin
        if (sb.size() == 0) begin
          check("unexpected_valid", 1, 0);
        end else begin
          e = sb.pop_front();
          check("fetch_cycle", cyc, e.cyc);
          check("fetch_data", instruction, e.data);
        end
      end else if (sb.size() != 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        check("missing_valid", 0, 1);
      end
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic fetch(input int a);
    exp_t e;
    fetch_en = 1'b1;
    address  = AW'(a);
    e.cyc  = cyc + 1;
    e.data = model[a];
    sb.push_back(e);
    step();
    fetch_en = 1'b0;
  endtask

  task automatic load_word(input logic [7:0] d, input logic last);
    load_valid = 1'b1;
    load_data  = d;
    load_last  = last;
    step();
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < 40) begin
      step();
      n++;
    end
    check(tag, n, DEPTH);
  endtask

  task automatic start_load();
    load_start = 1'b1;
    step();
    load_start = 1'b0;
  endtask

  initial begin
    int d0;
    rst = 1'b1; fetch_en = 1'b0; address = '0; load_start = 1'b0;
    load_valid = 1'b0; load_data = '0; load_last = 1'b0;
    for (int i = 0; i < DEPTH; i++) model[i] = FILL;

    // Reset state and clear latency
    repeat (2) step();
    check("rst_instruction", instruction, FILL);
    check("rst_instr_valid", instr_valid, 0);
    check("rst_busy", busy, 1);
    check("rst_load_ready", load_ready, 0);
    check("rst_load_done", load_done, 0);
    rst = 1'b0;
    wait_ready("clear_latency");
    for (int a = 0; a < DEPTH; a++) fetch(a);
    repeat (2) step();
    check("idle_valid", instr_valid, 0);

    // Full load of 0..15, no last flag: ends at the top address
    start_load();
    check("full_ready", load_ready, 1);
    check("full_busy_load", busy, 1);
    d0 = done_cnt;
    for (int i = 0; i < DEPTH; i++) begin
      check("full_no_early_done", load_done, 0);
      load_word(8'(i), 1'b0);
      model[i] = 8'(i);
    end
    check("full_done", load_done, 1);
    check("full_busy_after", busy, 0);
    check("full_ready_after", load_ready, 0);
    step();
    check("full_done_count", done_cnt - d0, 1);
    for (int a = 0; a < DEPTH; a++) fetch(a);
    fetch(7);
    repeat (2) step();
    check("hold_instruction", instruction, 8'h07);
    check("hold_valid", instr_valid, 0);

    // load_valid outside LOAD must not write
    address = 4'd3; load_valid = 1'b1; load_data = 8'hEE;
    repeat (2) step();
    load_valid = 1'b0;

    // Short load ended by load_last
    start_load();
    load_word(8'hA1, 1'b0);
    load_word(8'hA2, 1'b0);
    load_word(8'hA3, 1'b1);
    model[0] = 8'hA1; model[1] = 8'hA2; model[2] = 8'hA3;
    check("short_done", load_done, 1);
    for (int a = 0; a < 4; a++) fetch(a);

    // Gapped stream with load_start/fetch_en poked in the gaps
    start_load();
    for (int i = 0; i < 7; i++) begin
      if (i % 2 == 0) begin
        load_valid = 1'b1; load_data = 8'hB0 + 8'(i / 2); load_last = (i == 6);
        load_start = 1'b0; fetch_en = 1'b0;
      end else begin
        load_valid = 1'b0; load_data = 8'hEE; load_last = 1'b0;
        load_start = 1'b1; fetch_en = 1'b1; address = AW'(i);
      end
      step();
    end
    load_valid = 1'b0; load_last = 1'b0; load_start = 1'b0; fetch_en = 1'b0;
    check("gap_done", load_done, 1);
    for (int i = 0; i < 4; i++) model[i] = 8'hB0 + 8'(i);
    for (int a = 0; a < 6; a++) fetch(a);

    // Fetch and load_start in the same RUN cycle
    begin
      exp_t e;
      fetch_en = 1'b1; address = 4'd5; load_start = 1'b1;
      e.cyc = cyc + 1; e.data = model[5];
      sb.push_back(e);
      step();
      fetch_en = 1'b0; load_start = 1'b0;
    end
    check("simul_busy", busy, 1);
    check("simul_ready", load_ready, 1);
    load_word(8'hC5, 1'b1);
    model[0] = 8'hC5;
    check("simul_done", load_done, 1);
    fetch(0);
    fetch(5);

    // Reset in the middle of a load
    start_load();
    d0 = done_cnt;
    for (int i = 0; i < 4; i++) load_word(8'hD0 + 8'(i), 1'b0);
    rst = 1'b1; load_valid = 1'b1; load_data = 8'hEE;
    step();
    check("midrst_ready", load_ready, 0);
    check("midrst_busy", busy, 1);
    check("midrst_instruction", instruction, FILL);
    check("midrst_done", load_done, 0);
    rst = 1'b0; load_valid = 1'b0;
    wait_ready("midrst_clear_latency");
    check("midrst_done_count", done_cnt - d0, 0);
    for (int i = 0; i < DEPTH; i++) model[i] = FILL;
    for (int a = 0; a < DEPTH; a++) fetch(a);

    repeat (3) step();
    check("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
